sobel_grad_sq_stream: RTL and testbench
=======================================

# sobel_grad_sq_stream

Streaming Sobel gradient stage that sits directly upstream of the approximate square-root unit in the edge-detection datapath. It accepts 8-bit grayscale pixels in raster order and builds a 3x3 window from two internal line buffers. For every interior pixel it computes the horizontal and vertical Sobel gradients, then emits R = (|Gx|>>2)^2 + (|Gy|>>2)^2, saturated to 16 bits, on a valid/ready stream. That 16-bit R is the operand the square-root stage consumes to produce the 8-bit edge magnitude.

## Interface
- IMG_W, default 64: pixels per line, minimum 3.
- IMG_H, default 64: lines per frame, minimum 3.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock, asynchronous and active-low.
- pix_in  in  8  input pixel.
- pix_sof  in  1  marks the first pixel of a frame; qualified by the input handshake.
- pix_valid  in  1  pix_in is valid.
- pix_ready  out  1  block can accept a pixel.
- r_out  out  16  saturated gradient magnitude squared; this feeds the square-root stage's R.
- r_valid  out  1  r_out is valid.
- r_ready  in  1  downstream accepts r_out.
- r_last  out  1  marks the final output of a frame, for window centre (IMG_H-2, IMG_W-2).

## Operation
- **Input handshake.** A pixel is accepted on any cycle where pix_valid && pix_ready.
- **Position counters.** col and row are counters indexed from 0.
  - An accepted pixel with pix_sof=1 is taken as position (0,0), whatever the counter state.
  - After an accept at (row, IMG_W-1), col wraps to 0 and row increments.
  - After an accept at (IMG_H-1, IMG_W-1), both counters wrap to (0,0) without needing pix_sof.
- **Line buffers.**
  - There are two IMG_W x 8 line buffers; each column is written as its pixel is accepted.
  - Buffer contents are not reset. Rows 0-1 never produce output, so this is harmless.
- **Window.** p[i][j] has i = row offset and j = column offset, with 0 the oldest and 2 the newest.
  - The window is shifted in on each accept, so accepting (row, col) forms the window centred at (row-1, col-1).
- **Output gating.** An output is generated only when row >= 2 and col >= 2. That gives (IMG_H-2)*(IMG_W-2) outputs per frame.
- **Arithmetic.** Full precision is kept until the shift.
  - Gx = (p02 + 2p12 + p22) - (p00 + 2p10 + p20), 11-bit signed.
  - Gy = (p20 + 2p21 + p22) - (p00 + 2p01 + p02), 11-bit signed.
  - ax = |Gx|>>2 and ay = |Gy|>>2, each 8 bits, at most 255.
  - S = ax*ax + ay*ay, 17 bits.
  - r_out = 16'hFFFF if S > 65535, otherwise S[15:0].
- **Pipeline.** Three stages:
  - S0: accept the pixel, update the window and read/write the line buffers.
  - S1: compute Gx and Gy.
  - S2: square, sum and saturate into the output register.
- **Backpressure.** The stall is global: pix_ready = !(r_valid && !r_ready).
  - While stalled, every stage and both counters hold.
  - No output is dropped or duplicated.

## Timing
- **Reset values.** pix_ready=1, r_valid=0, r_out=0, r_last=0. Counters go to (0,0), window registers and pipeline valids to 0.
- **Latency.** An accept at cycle t that produces an output gives r_valid=1 at cycle t+2, provided there is no stall.
- **Throughput.** One pixel per clock when r_ready is held high.
- **Holding outputs.** r_out and r_last hold steady while r_valid && !r_ready.
- **Mid-frame pix_sof.** Counters restart at (0,0). Outputs already in flight still complete.
- **Mid-stream reset.** All in-flight results are discarded. The first pixel after reset is (0,0).

## Configuration
- **SOBEL_SAT_CNT_EN defined.** Adds output port sat_cnt (16 bits).
  - It increments on each output handshake whose S > 65535, and saturates at 16'hFFFF.
  - It clears to 0 on reset and on an accepted pix_sof.
- **SOBEL_SAT_CNT_EN undefined.** The sat_cnt port and its logic do not exist. Datapath behaviour is identical.

## Test plan
- **Flat image.** IMG_W=8, IMG_H=4, every pixel 100 -> 12 outputs, all r_out=0. r_last only on the 12th. First r_valid two cycles after the accept of (2,2).
- **Vertical step.** IMG_W=8, IMG_H=4, columns 0-3 = 0 and 4-7 = 200:
  - window centres at col 3 and col 4 -> r_out=40000 (Gx=800, ax=200);
  - all other outputs 0.
- **Diagonal saturation.** Pixel = 255 when row+col >= 3, else 0 -> first output (centre (1,1)): Gx=Gy=765, ax=ay=191, S=72962, r_out=16'hFFFF. With SOBEL_SAT_CNT_EN, sat_cnt is 1 after that handshake.
- **Backpressure.** Continuous input; r_ready low for 5 cycles mid-row -> pix_ready low for those cycles and r_out held stable. After release, the output sequence matches the no-stall golden model exactly.
- **Resync and wrap.** pix_sof asserted at an arbitrary mid-frame position -> counters restart at (0,0) and outputs resume at the new (2,2). Two back-to-back frames without pix_sof -> 2*(IMG_H-2)*(IMG_W-2) outputs and two r_last pulses.
- **Reset mid-frame.** Assert rst_n low with r_valid=1 -> r_valid=0, r_out=0 and pix_ready=1 immediately, without waiting for a clock edge. The next frame's outputs are correct.

Source files
------------

// File: rtl/sobel_grad_sq_stream.sv
// -----------------------------------------------------------------------------
// sobel_grad_sq_stream
//
// This is a streaming Sobel gradient stage. It takes 8-bit pixels in raster
// order and builds a 3x3 window from two line buffers. For every interior
// pixel it emits
//   R = (|Gx|>>2)^2 + (|Gy|>>2)^2
// saturated to 16 bits. R is the operand of the downstream square-root stage.
//
// Pipeline:
//   S0  accept pixel, shift window, read/write line buffers
//   S1  Gx / Gy register
//   S2  square, sum, saturate into the output register
// The stall is global: every stage and the position counters freeze while an
// output is waiting on r_ready.
//
// Parameters: IMG_W, IMG_H (pixels per line / lines per frame, each >= 3)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   pix_in     8-bit input pixel
//   pix_sof    first pixel of a frame (forces position (0,0))
//   pix_valid  pix_in valid
//   pix_ready  block can accept a pixel
//   r_out      saturated gradient magnitude squared
//   r_valid    r_out valid
//   r_ready    downstream accepts r_out
//   r_last     final output of the frame (centre IMG_H-2, IMG_W-2)
//   sat_cnt    (only with SOBEL_SAT_CNT_EN) count of saturated outputs
//
// Optional feature macro: SOBEL_SAT_CNT_EN
// -----------------------------------------------------------------------------
module sobel_grad_sq_stream #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  pix_in,
  input  logic        pix_sof,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [15:0] r_out,
  output logic        r_valid,
  input  logic        r_ready,
  output logic        r_last
`ifdef SOBEL_SAT_CNT_EN
  ,
  output logic [15:0] sat_cnt
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO = CW'(2);
  localparam logic [RW-1:0] ROW_TWO = RW'(2);

  logic en;
  logic accept;

  assign en        = !(r_valid && !r_ready);
  assign pix_ready = en;
  assign accept    = pix_valid && en;

  // ---------------------------------------------------------------------------
  // Position counters. pix_sof overrides the counters for the current pixel,
  // so the effective position drives every decision that is made at accept.
  // ---------------------------------------------------------------------------
  logic [CW-1:0] col;
  logic [CW-1:0] eff_col;
  logic [RW-1:0] row;
  logic [RW-1:0] eff_row;

  // NOTE: every signal written in always_comb gets a value on every path,
  //       which keeps the block free of inferred latches.
  always_comb begin
    eff_col = col;
    eff_row = row;
    if (pix_sof) begin
      eff_col = '0;
      eff_row = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments, so every register
  //       samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (eff_col == COL_MAX) begin
        col <= '0;
        row <= (eff_row == ROW_MAX) ? '0 : eff_row + RW'(1);
      end else begin
        col <= eff_col + CW'(1);
        row <= eff_row;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffers. lb_old holds row-2 and lb_mid holds row-1 at each column.
  // ---------------------------------------------------------------------------
  logic [7:0] lb_old [IMG_W];
  logic [7:0] lb_mid [IMG_W];

  // NOTE: the line buffers are plain memories without a reset. Their contents
  //       only reach the output from row 2 onwards, and by then this frame
  //       has overwritten them.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_old[eff_col] <= lb_mid[eff_col];
      lb_mid[eff_col] <= pix_in;
    end
  end

  // ---------------------------------------------------------------------------
  // S0: 3x3 window, win[row offset][col offset], index 2 = newest.
  // ---------------------------------------------------------------------------
  logic [7:0] win [3][3];
  logic       v0;
  logic       last0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win[i][j] <= '0;
      v0    <= 1'b0;
      last0 <= 1'b0;
    end else if (en) begin
      if (accept) begin
        for (int i = 0; i < 3; i++) begin
          win[i][0] <= win[i][1];
          win[i][1] <= win[i][2];
        end
        win[0][2] <= lb_old[eff_col];
        win[1][2] <= lb_mid[eff_col];
        win[2][2] <= pix_in;
      end
      v0    <= accept && (eff_row >= ROW_TWO) && (eff_col >= COL_TWO);
      last0 <= accept && (eff_row == ROW_MAX) && (eff_col == COL_MAX);
    end
  end

  // ---------------------------------------------------------------------------
  // S1: Sobel gradients, kept at full 11-bit signed precision.
  // ---------------------------------------------------------------------------
  logic [9:0]         gx_pos, gx_neg, gy_pos, gy_neg;
  logic signed [10:0] gx_c, gy_c;
  logic signed [10:0] gx, gy;
  logic               v1;
  logic               last1;

  always_comb begin
    gx_pos = {2'b0, win[0][2]} + {1'b0, win[1][2], 1'b0} + {2'b0, win[2][2]};
    gx_neg = {2'b0, win[0][0]} + {1'b0, win[1][0], 1'b0} + {2'b0, win[2][0]};
    gy_pos = {2'b0, win[2][0]} + {1'b0, win[2][1], 1'b0} + {2'b0, win[2][2]};
    gy_neg = {2'b0, win[0][0]} + {1'b0, win[0][1], 1'b0} + {2'b0, win[0][2]};
    gx_c   = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
    gy_c   = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx    <= '0;
      gy    <= '0;
      v1    <= 1'b0;
      last1 <= 1'b0;
    end else if (en) begin
      gx    <= gx_c;
      gy    <= gy_c;
      v1    <= v0;
      last1 <= last0;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: magnitude, square, sum, saturate. |G| <= 1020, so ax/ay <= 255 and
  // S <= 130050. S therefore exceeds 65535 exactly when bit 16 is set.
  // ---------------------------------------------------------------------------
  logic [10:0] mag_x, mag_y;
  logic [16:0] ax_w, ay_w;
  logic [16:0] sq_sum;
  logic        sat;
  logic [15:0] r_next;

  always_comb begin
    mag_x  = gx[10] ? 11'(-gx) : 11'(gx);
    mag_y  = gy[10] ? 11'(-gy) : 11'(gy);
    ax_w   = {9'b0, 8'(mag_x >> 2)};
    ay_w   = {9'b0, 8'(mag_y >> 2)};
    sq_sum = ax_w * ax_w + ay_w * ay_w;
    sat    = sq_sum[16];
    r_next = sat ? 16'hFFFF : sq_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_out   <= '0;
      r_last  <= 1'b0;
    end else if (en) begin
      r_valid <= v1;
      r_last  <= v1 && last1;
      if (v1) r_out <= r_next;
    end
  end

`ifdef SOBEL_SAT_CNT_EN
  // The saturation flag travels with r_out so that the count follows the
  // output handshake rather than the computation.
  logic r_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat <= 1'b0;
    end else if (en) begin
      r_sat <= v1 && sat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (accept && pix_sof) begin
      sat_cnt <= '0;
    end else if (r_valid && r_ready && r_sat && (sat_cnt != 16'hFFFF)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sobel_grad_sq_stream.sv
// -----------------------------------------------------------------------------
// tb_sobel_grad_sq_stream
//
// Directed bench for sobel_grad_sq_stream with IMG_W=8 and IMG_H=4.
// - A table of hand-computed {pattern, output index, r_out, r_last} records
//   is checked against the flat, vertical-step and diagonal frames.
// - A direct 2-D Sobel model supplies the full expected output sequence of
//   every frame.
// - Hand-written sequences cover backpressure, resync by pix_sof, frame wrap,
//   and an asynchronous reset in mid-frame.
// -----------------------------------------------------------------------------
module tb_sobel_grad_sq_stream;

  localparam int W = 8;
  localparam int H = 4;

  logic        clk;
  logic        rst_n;
  logic [7:0]  pix_in;
  logic        pix_sof;
  logic        pix_valid;
  logic        pix_ready;
  logic [15:0] r_out;
  logic        r_valid;
  logic        r_ready;
  logic        r_last;
`ifdef SOBEL_SAT_CNT_EN
  logic [15:0] sat_cnt;
`endif

  sobel_grad_sq_stream #(.IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_in    (pix_in),
    .pix_sof   (pix_sof),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .r_out     (r_out),
    .r_valid   (r_valid),
    .r_ready   (r_ready),
    .r_last    (r_last)
`ifdef SOBEL_SAT_CNT_EN
    ,
    .sat_cnt   (sat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pix;
    logic       sof;
    logic       mark;
  } pix_t;

  typedef struct {
    logic [15:0] r;
    logic        last;
  } out_t;

  typedef struct {
    int          pattern;
    int          idx;
    logic [15:0] exp_r;
    logic        exp_last;
  } vec_t;

  pix_t pix_q[$];
  out_t out_q[$];
  out_t exp_q[$];
  int   img [H][W];

  int n_cmp  = 0;
  int n_fail = 0;
  int first_valid_cyc;
  int mark_acc_cyc;
  int n_sat_model;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // 0 flat, 1 vertical step, 2 diagonal, otherwise random
  task automatic fill(input int pat);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (pat)
          0:       img[r][c] = 100;
          1:       img[r][c] = (c >= 4) ? 200 : 0;
          2:       img[r][c] = (r + c >= 3) ? 255 : 0;
          default: img[r][c] = int'($urandom_range(0, 255));
        endcase
  endtask

  task automatic enqueue_frame(input bit sof, input int npix, input int mark_idx);
    pix_t p;
    for (int i = 0; i < npix; i++) begin
      p.pix  = 8'(img[i / W][i % W]);
      p.sof  = sof && (i == 0);
      p.mark = (i == mark_idx);
      pix_q.push_back(p);
    end
  endtask

  // Direct 2-D Sobel over the current image; keeps the first `keep` outputs.
  task automatic model_frame(input int keep);
    int   gx, gy, ax, ay, s, n;
    out_t o;
    n = 0;
    n_sat_model = 0;
    for (int r = 1; r < H - 1; r++)
      for (int c = 1; c < W - 1; c++) begin
        gx = (img[r-1][c+1] + 2 * img[r][c+1] + img[r+1][c+1])
           - (img[r-1][c-1] + 2 * img[r][c-1] + img[r+1][c-1]);
        gy = (img[r+1][c-1] + 2 * img[r+1][c] + img[r+1][c+1])
           - (img[r-1][c-1] + 2 * img[r-1][c] + img[r-1][c+1]);
        ax = ((gx < 0) ? -gx : gx) / 4;
        ay = ((gy < 0) ? -gy : gy) / 4;
        s  = ax * ax + ay * ay;
        if (n < keep) begin
          o.r    = (s > 65535) ? 16'hFFFF : 16'(s);
          o.last = (r == H - 2) && (c == W - 2);
          exp_q.push_back(o);
          if (s > 65535) n_sat_model++;
        end
        n++;
      end
  endtask

  // Streams pix_q with r_ready low for cycles [stall_lo, stall_hi). Inputs
  // change 1 time unit after the rising edge; outputs are sampled on the
  // falling edge.
  task automatic run_stream(input int stall_lo, input int stall_hi);
    int   cyc;
    int   idle;
    bit   hold_chk;
    out_t held;
    cyc = 0;
    idle = 0;
    hold_chk = 0;
    held.r = '0;
    held.last = 1'b0;
    first_valid_cyc = -1;
    mark_acc_cyc = -1;
    out_q.delete();
    while (idle < 8 && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
      pix_valid = (pix_q.size() > 0);
      pix_in    = pix_valid ? pix_q[0].pix : 8'd0;
      pix_sof   = pix_valid ? pix_q[0].sof : 1'b0;
      r_ready   = !(cyc >= stall_lo && cyc < stall_hi);
      @(negedge clk);
      if (hold_chk) begin
        check("held_r_valid", r_valid, 1);
        check("held_r_out", r_out, held.r);
        check("held_r_last", r_last, held.last);
      end
      hold_chk  = r_valid && !r_ready;
      held.r    = r_out;
      held.last = r_last;
      if (cyc >= stall_lo && cyc < stall_hi)
        check("stall_pix_ready", pix_ready, 0);
      if (r_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (r_valid && r_ready) out_q.push_back(held);
      if (pix_valid && pix_ready) begin
        if (pix_q[0].mark) mark_acc_cyc = cyc + 1;
        void'(pix_q.pop_front());
      end
      if (pix_q.size() == 0 && !r_valid) idle++;
      else idle = 0;
    end
    check("stream_drained", idle >= 8, 1);
    #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    r_ready   = 1'b1;
  endtask

  task automatic compare_outputs(input string tag);
    int n;
    check($sformatf("%s_count", tag), out_q.size(), exp_q.size());
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_r[%0d]", tag, i), out_q[i].r, exp_q[i].r);
      check($sformatf("%s_last[%0d]", tag, i), out_q[i].last, exp_q[i].last);
    end
  endtask

  initial begin
    vec_t vecs[12];
    int   n_last;

    // Hand-computed expectations: output index k is centre (1 + k/6, 1 + k%6).
    vecs[0]  = '{0, 0,  16'd0,     1'b0};
    vecs[1]  = '{0, 11, 16'd0,     1'b1};
    vecs[2]  = '{1, 0,  16'd0,     1'b0};
    vecs[3]  = '{1, 2,  16'd40000, 1'b0};
    vecs[4]  = '{1, 3,  16'd40000, 1'b0};
    vecs[5]  = '{1, 5,  16'd0,     1'b0};
    vecs[6]  = '{1, 8,  16'd40000, 1'b0};
    vecs[7]  = '{1, 9,  16'd40000, 1'b0};
    vecs[8]  = '{2, 0,  16'hFFFF,  1'b0};
    vecs[9]  = '{2, 1,  16'hFFFF,  1'b0};
    vecs[10] = '{2, 11, 16'd0,     1'b1};
    vecs[11] = '{1, 11, 16'd0,     1'b1};

    rst_n     = 1'b0;
    pix_in    = 8'd0;
    pix_sof   = 1'b0;
    pix_valid = 1'b0;
    r_ready   = 1'b1;
    #12;
    check("reset_pix_ready", pix_ready, 1);
    check("reset_r_valid", r_valid, 0);
    check("reset_r_out", r_out, 0);
    check("reset_r_last", r_last, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven frames: flat, vertical step, diagonal saturation.
    for (int p = 0; p < 3; p++) begin
      fill(p);
      exp_q.delete();
      enqueue_frame(1'b1, W * H, 2 * W + 2);
      model_frame(1000);
      run_stream(-1, -1);
      check($sformatf("latency_p%0d", p), first_valid_cyc, mark_acc_cyc + 2);
      compare_outputs($sformatf("frame_p%0d", p));
      for (int v = 0; v < 12; v++)
        if (vecs[v].pattern == p) begin
          if (vecs[v].idx < out_q.size()) begin
            check($sformatf("vec%0d_r", v), out_q[vecs[v].idx].r, vecs[v].exp_r);
            check($sformatf("vec%0d_last", v), out_q[vecs[v].idx].last, vecs[v].exp_last);
          end else begin
            check($sformatf("vec%0d_present", v), out_q.size(), vecs[v].idx + 1);
          end
        end
`ifdef SOBEL_SAT_CNT_EN
      if (p == 2) check("sat_cnt_diag", sat_cnt, n_sat_model);
`endif
    end

    // Backpressure: r_ready low for 5 cycles while row-2 outputs are flowing.
    fill(9);
    exp_q.delete();
    enqueue_frame(1'b1, W * H, -1);
    model_frame(1000);
    run_stream(23, 28);
    compare_outputs("stall");

    // Resync: pix_sof mid-frame after (2,4); three outputs already in flight.
    fill(9);
    exp_q.delete();
    enqueue_frame(1'b1, 2 * W + 5, -1);
    model_frame(3);
    fill(9);
    enqueue_frame(1'b1, W * H, -1);
    model_frame(1000);
    run_stream(-1, -1);
    compare_outputs("resync");

    // Wrap: two frames back to back, pix_sof only on the first pixel.
    fill(9);
    exp_q.delete();
    enqueue_frame(1'b1, W * H, -1);
    model_frame(1000);
    fill(9);
    enqueue_frame(1'b0, W * H, -1);
    model_frame(1000);
    run_stream(-1, -1);
    compare_outputs("wrap");
    n_last = 0;
    foreach (out_q[i]) if (out_q[i].last) n_last++;
    check("wrap_last_pulses", n_last, 2);

    // Reset mid-frame with r_valid high and the pipeline stalled.
    fill(9);
    pix_q.delete();
    enqueue_frame(1'b1, W * H, -1);
    r_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      pix_valid = (pix_q.size() > 0);
      pix_in    = pix_valid ? pix_q[0].pix : 8'd0;
      pix_sof   = pix_valid ? pix_q[0].sof : 1'b0;
      @(negedge clk);
      if (r_valid) break;
      if (pix_valid && pix_ready) void'(pix_q.pop_front());
    end
    check("pre_reset_r_valid", r_valid, 1);
    r_ready = 1'b0;
    #1;
    check("pre_reset_pix_ready", pix_ready, 0);
    rst_n = 1'b0;
    #1;
    check("async_reset_r_valid", r_valid, 0);
    check("async_reset_r_out", r_out, 0);
    check("async_reset_r_last", r_last, 0);
    check("async_reset_pix_ready", pix_ready, 1);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    r_ready   = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    pix_q.delete();

    // After reset the first pixel is (0,0) even without pix_sof.
    fill(9);
    exp_q.delete();
    enqueue_frame(1'b0, W * H, -1);
    model_frame(1000);
    run_stream(-1, -1);
    compare_outputs("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
